auth_cmd_rx: RTL and testbench
==============================

Name: auth_cmd_rx

Overview:
Serial command front-end inside the Segway DUT, directly downstream of the BLE/host UART link (the RX pin driven by the bench's UART_tx).
It deserialises 8N1 bytes from RX and runs the authorisation state machine that produces pwr_up.
pwr_up enables the balance controller and steering/motor drive.
Power-down on 'S' is deferred until the rider has stepped off (rider_off from the load-cell logic).

Parameters:
BAUD_CYC, 2604, clk cycles per bit (50 MHz clk, 19200 baud)
CMD_GO, 8'h47, ASCII 'G': authorise/power up
CMD_STOP, 8'h53, ASCII 'S': request power down

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset (already synchronised at top)
RX  in  1  UART serial input, idle high, asynchronous to clk
rider_off  in  1  high when load cells indicate no rider
pwr_up  out  1  registered enable to balance/steer/motor logic
rx_byte  out  8  last correctly framed byte (debug/visibility)
frm_err  out  1  one-cycle pulse when a frame's stop bit samples low

Behaviour:
- Reset values: pwr_up=0, rx_byte=8'h00, frm_err=0, receiver IDLE, auth FSM OFF. Synchroniser flops reset to 1 (idle line).
- RX path:
  - Double-flop synchroniser, both flops preset high.
  - Receiver acts on the second flop only.
- Receiver FSM (sub-module):
  - IDLE: a high-to-low transition of synchronised RX moves to START and loads the baud counter with BAUD_CYC/2.
  - START: at counter expiry, sample RX. If 0, go to DATA with counter=BAUD_CYC and bit count=0. If 1 (glitch), return to IDLE.
  - DATA: shift in one bit per expiry, LSB first, into a shift register. After 8 bits go to STOP.
  - STOP: at expiry, sample RX.
    - If 1: rx_byte <= shift register, pulse rdy for exactly 1 cycle, go to IDLE.
    - If 0: pulse frm_err, do not update rx_byte, no rdy. Wait in IDLE until RX has been high for one full bit before re-arming.
  - Baud counter is 12 bits, down-counting. Expiry is count==1; reload happens on the same cycle.
- Auth FSM (states OFF, PWR1, PWR2), evaluated each cycle; rdy qualifies byte compares:
  - OFF: rdy & byte==CMD_GO -> PWR1.
  - PWR1:
    - rdy & byte==CMD_STOP & rider_off -> OFF.
    - rdy & byte==CMD_STOP & !rider_off -> PWR2.
  - PWR2:
    - rider_off -> OFF.
    - rdy & byte==CMD_GO -> PWR1 (cancels the pending stop).
  - Any other byte value, or a framing error: no state change.
- pwr_up is registered: 1 in PWR1/PWR2, 0 in OFF. It updates on the clock edge after the state transition.
- Latency:
  - From the mid-stop-bit sample to the rdy pulse: 1 clk.
  - From rdy to the auth state change: 1 clk.
  - From the auth state change to pwr_up: 1 clk.
  - Total: 2 clk after rdy.
- Simultaneous events:
  - In PWR2, if rider_off=1 and a 'G' byte arrive on the same cycle, OFF wins.
  - In OFF, rider_off has no effect.
- Back-to-back frames: a start edge immediately following the stop-bit sample must be accepted. No dead time beyond the synchroniser.
- Reset mid-frame aborts the frame with no rdy or frm_err, and returns everything to its reset values.

Decomposition:
- Shared package entries:
  - auth_state_t enum {OFF, PWR1, PWR2}.
  - CMD_GO and CMD_STOP localparams, which the bench also uses to send commands.
  - BAUD_CYC default.
- One sub-module, auth_uart_rx:
  - Contains the synchroniser, baud counter, bit counter, shift register and receiver FSM.
  - Outputs rx_byte, rdy and frm_err.
- The auth FSM and the pwr_up register live in auth_cmd_rx.

Test Plan:
1. Reset, rider_off=0, send 'G' (0x47) -> rx_byte=0x47; pwr_up 0->1 exactly 2 clk after rdy, about 9.5*2604 clk after the start edge.
2. Powered, rider_off=0, send 'S' -> pwr_up stays 1 (PWR2). Then hold rider_off=1 for 1 clk -> pwr_up=0 within 2 clk.
3. Powered, rider_off=1, send 'S' -> pwr_up falls 2 clk after rdy. Then send 'S' again -> no change.
4. PWR2, send 'G', then raise rider_off -> pwr_up remains 1 (back in PWR1).
5. Send 0x41, then a frame with stop bit forced 0 carrying 0x47 -> no pwr_up change; frm_err pulses once; rx_byte keeps 0x41.
6. Assert rst_n low at data bit 4 of a 'G' frame, release, then send a clean 'G' -> no power-up from the aborted frame; the clean frame powers up normally.

Source files
------------

// File: rtl/auth_cmd_rx_pkg.sv
// Shared types and constants for the authorisation command receiver.
// Command codes are also used by the bench to build stimulus.
package auth_cmd_rx_pkg;

  localparam logic [7:0]  CMD_GO       = 8'h47;  // 'G'
  localparam logic [7:0]  CMD_STOP     = 8'h53;  // 'S'
  localparam int unsigned BAUD_CYC_DEF = 2604;   // 50 MHz / 19200 baud
  localparam int unsigned CNT_W        = 12;

  typedef enum logic [1:0] {
    OFF,
    PWR1,
    PWR2
  } auth_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/auth_uart_rx.sv
// 8N1 UART receiver: RX synchroniser, baud/bit counters, shift register and
// receiver FSM. Produces the framed byte, a one-cycle rdy and frm_err.
module auth_uart_rx
  import auth_cmd_rx_pkg::*;
#(
  parameter int unsigned BAUD_CYC = BAUD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_byte,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(BAUD_CYC);
  localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(BAUD_CYC / 2);

  logic rx_ff1, rx_ff2, rx_prev;
  logic fall, expired;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       byte_q, byte_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;
  logic             rearm_q, rearm_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= RX;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  assign fall    = rx_prev & ~rx_ff2;
  assign expired = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    byte_d  = byte_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    rearm_d = rearm_q;
    unique case (state_q)
      RX_IDLE: begin
        // After a framing error, the line must stay high for a full bit
        // before a new start edge is honoured.
        if (rearm_q) begin
          if (!rx_ff2)      cnt_d   = BAUD_FULL;
          else if (expired) rearm_d = 1'b0;
          else              cnt_d   = cnt_q - CNT_W'(1);
        end else if (fall) begin
          state_d = RX_START;
          cnt_d   = BAUD_HALF;
        end
      end
      RX_START: begin
        if (expired) begin
          if (!rx_ff2) begin
            state_d = RX_DATA;
            cnt_d   = BAUD_FULL;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (expired) begin
          sh_d  = {rx_ff2, sh_q[7:1]};
          cnt_d = BAUD_FULL;
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (expired) begin
          state_d = RX_IDLE;
          if (rx_ff2) begin
            byte_d = sh_q;
            rdy_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            rearm_d = 1'b1;
            cnt_d   = BAUD_FULL;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      byte_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      byte_q  <= byte_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      rearm_q <= rearm_d;
    end
  end

  assign rx_byte = byte_q;
  assign rdy     = rdy_q;
  assign frm_err = err_q;

endmodule

// File: rtl/auth_cmd_rx.sv
// Serial command front-end: UART receiver plus the authorisation FSM that
// drives pwr_up. A stop request is deferred until the rider has stepped off.
module auth_cmd_rx
  import auth_cmd_rx_pkg::*;
#(
  parameter int unsigned BAUD_CYC = BAUD_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] rx_byte,
  output logic       frm_err
);

  logic        rdy;
  logic        is_go, is_stop;
  auth_state_t state_q, state_d;

  auth_uart_rx #(
    .BAUD_CYC(BAUD_CYC)
  ) u_rx (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .rx_byte(rx_byte),
    .rdy    (rdy),
    .frm_err(frm_err)
  );

  assign is_go   = rdy && (rx_byte == CMD_GO);
  assign is_stop = rdy && (rx_byte == CMD_STOP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:  if (is_go) state_d = PWR1;
      PWR1: if (is_stop) state_d = rider_off ? OFF : PWR2;
      // rider_off takes priority over a 'G' arriving on the same cycle
      PWR2: begin
        if (rider_off)  state_d = OFF;
        else if (is_go) state_d = PWR1;
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      pwr_up  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwr_up  <= (state_q != OFF);
    end
  end

endmodule

// File: tb/tb_auth_cmd_rx.sv
// Directed bench for auth_cmd_rx, run with a short bit time; expected
// latencies are hand-derived from the frame timing.
module tb_auth_cmd_rx;
  import auth_cmd_rx_pkg::*;

  localparam int B   = 32;
  localparam int H   = B / 2;
  localparam int LAT = 9 * B + H + 4;   // start-edge drive cycle to pwr_up change

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       rider_off;
  logic       pwr_up;
  logic [7:0] rx_byte;
  logic       frm_err;

  int n_cmp = 0;
  int n_bad = 0;

  auth_cmd_rx #(
    .BAUD_CYC(B)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .rider_off(rider_off),
    .pwr_up   (pwr_up),
    .rx_byte  (rx_byte),
    .frm_err  (frm_err)
  );

  always #5 clk = ~clk;

  // Drives one frame; chg = cycle index of first pwr_up change (-1 if none).
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int stop_len, input int ro_at, input int abort_at,
                            output int chg, output int ferr);
    logic p0;
    int   b;
    int   total;
    total = 9 * B + stop_len;
    chg   = -1;
    ferr  = 0;
    p0    = pwr_up;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        rst_n = 1'b0;
        RX    = 1'b1;
        break;
      end
      b = k / B;
      if (k % B == 0) begin
        if (b == 0)      RX = 1'b0;
        else if (b <= 8) RX = data[b-1];
        else             RX = stop_bit;
      end
      if (k == ro_at) rider_off = 1'b1;
      @(posedge clk); #1;
      if (pwr_up !== p0 && chg < 0) chg = k;
      if (frm_err === 1'b1) ferr++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      RX = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; RX = 1'b1; rider_off = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (pwr_up !== 1'b0) begin n_bad++; $display("FAIL reset_pwr_up: got %b want 0", pwr_up); end
    n_cmp++; if (rx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
    n_cmp++; if (frm_err !== 1'b0) begin n_bad++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
    @(negedge clk); rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_power_up;
    int chg, ferr;
    send_frame(CMD_GO, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (rx_byte !== 8'h47) begin n_bad++; $display("FAIL go_rx_byte: got %h want 47", rx_byte); end
    n_cmp++; if (chg !== LAT) begin n_bad++; $display("FAIL go_latency: got %0d want %0d", chg, LAT); end
    n_cmp++; if (pwr_up !== 1'b1) begin n_bad++; $display("FAIL go_pwr_up: got %b want 1", pwr_up); end
    n_cmp++; if (ferr !== 0) begin n_bad++; $display("FAIL go_frm_err: got %0d pulses want 0", ferr); end
  endtask

  task automatic test_stop_deferred;
    int chg, ferr;
    send_frame(CMD_STOP, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (rx_byte !== 8'h53) begin n_bad++; $display("FAIL sdef_rx_byte: got %h want 53", rx_byte); end
    n_cmp++; if (chg !== -1) begin n_bad++; $display("FAIL sdef_no_change: got %0d want -1", chg); end
    @(negedge clk); rider_off = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (pwr_up !== 1'b1) begin n_bad++; $display("FAIL sdef_lat1: got %b want 1", pwr_up); end
    @(negedge clk); rider_off = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (pwr_up !== 1'b0) begin n_bad++; $display("FAIL sdef_off: got %b want 0", pwr_up); end
  endtask

  task automatic test_stop_immediate;
    int chg, ferr;
    send_frame(CMD_GO, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (chg !== LAT) begin n_bad++; $display("FAIL simm_go: got %0d want %0d", chg, LAT); end
    rider_off = 1'b1;
    send_frame(CMD_STOP, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (chg !== LAT) begin n_bad++; $display("FAIL simm_stop_lat: got %0d want %0d", chg, LAT); end
    n_cmp++; if (pwr_up !== 1'b0) begin n_bad++; $display("FAIL simm_pwr_up: got %b want 0", pwr_up); end
    send_frame(CMD_STOP, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (chg !== -1 || pwr_up !== 1'b0) begin n_bad++; $display("FAIL simm_stop_again: got chg %0d pwr %b want -1 0", chg, pwr_up); end
    @(negedge clk); rider_off = 1'b0;
  endtask

  task automatic test_cancel_stop;
    int chg, ferr;
    send_frame(CMD_GO, 1'b1, B, -1, -1, chg, ferr);
    send_frame(CMD_STOP, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (chg !== -1) begin n_bad++; $display("FAIL cancel_pwr2: got %0d want -1", chg); end
    send_frame(CMD_GO, 1'b1, B, -1, -1, chg, ferr);
    @(negedge clk); rider_off = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_cmp++; if (pwr_up !== 1'b1) begin n_bad++; $display("FAIL cancel_hold: got %b want 1", pwr_up); end
    @(negedge clk); rider_off = 1'b0;
    // PWR2 with rider_off and 'G' landing together: OFF must win
    send_frame(CMD_STOP, 1'b1, B, -1, -1, chg, ferr);
    send_frame(CMD_GO, 1'b1, B, LAT - 1, -1, chg, ferr);
    n_cmp++; if (chg !== LAT || pwr_up !== 1'b0) begin n_bad++; $display("FAIL simul_off_wins: got chg %0d pwr %b want %0d 0", chg, pwr_up, LAT); end
    @(negedge clk); rider_off = 1'b0;
  endtask

  task automatic test_frame_error;
    int chg, ferr;
    send_frame(8'h41, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (rx_byte !== 8'h41) begin n_bad++; $display("FAIL ferr_prev_byte: got %h want 41", rx_byte); end
    send_frame(CMD_GO, 1'b0, B, -1, -1, chg, ferr);
    n_cmp++; if (ferr !== 1) begin n_bad++; $display("FAIL ferr_pulse: got %0d pulses want 1", ferr); end
    n_cmp++; if (rx_byte !== 8'h41) begin n_bad++; $display("FAIL ferr_rx_byte: got %h want 41", rx_byte); end
    n_cmp++; if (chg !== -1) begin n_bad++; $display("FAIL ferr_no_pwr: got %0d want -1", chg); end
    idle(2 * B + 4);
  endtask

  task automatic test_back_to_back;
    int chg, ferr;
    send_frame(8'h41, 1'b1, H + 1, -1, -1, chg, ferr);
    send_frame(CMD_GO, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (chg !== LAT) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", chg, LAT); end
    n_cmp++; if (rx_byte !== 8'h47) begin n_bad++; $display("FAIL b2b_rx_byte: got %h want 47", rx_byte); end
  endtask

  task automatic test_reset_midframe;
    int chg, ferr, errs;
    send_frame(CMD_GO, 1'b1, B, -1, 5 * B + 10, chg, ferr);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pwr_up !== 1'b0 || rx_byte !== 8'h00) begin n_bad++; $display("FAIL mid_reset_vals: got pwr %b byte %h want 0 00", pwr_up, rx_byte); end
    @(negedge clk); rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 2 * B; i++) begin
      @(posedge clk); #1;
      if (frm_err === 1'b1 || pwr_up !== 1'b0) errs++;
    end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL mid_abort_quiet: got %0d bad cycles want 0", errs); end
    send_frame(CMD_GO, 1'b1, B, -1, -1, chg, ferr);
    n_cmp++; if (chg !== LAT || rx_byte !== 8'h47) begin n_bad++; $display("FAIL mid_clean_go: got chg %0d byte %h want %0d 47", chg, rx_byte, LAT); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_stop_deferred();
    test_stop_immediate();
    test_cancel_stop();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
